pipe_ctrl_seq: RTL

//  Central pipeline sequencer for the 5-stage core.
//  - Merges stall requests from IF/ID/EX/MEM into the 6-bit stall vector consumed by pc_reg and every stage register.
//  - Turns MEM-stage exceptions into a flush plus a redirect PC, and holds the flush for a configurable window.
//  - Keeps saturating stall/exception statistics and a stall watchdog.

---
 rtl/pipe_ctrl_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_seq.sv
// Pipeline sequencer: merges stage stall requests, turns MEM exceptions into
// flush + redirect, and keeps saturating stall/exception statistics plus a stall watchdog.
module pipe_ctrl_seq #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int unsigned FLUSH_LEN     = 1,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] exc_count,
  output logic             stall_timeout
);

  localparam int unsigned HOLD_W = 4;
  localparam int unsigned RUN_W  = $clog2(STALL_TIMEOUT + 1);

  localparam logic [0:0] ST_RUN        = 1'b0;
  localparam logic [0:0] ST_FLUSH_HOLD = 1'b1;

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  logic [0:0]       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             timeout_q, timeout_d;
  logic             exc_accept;

  // Next-state and combinational pipeline controls
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    pc_d       = pc_q;
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'h0000_0000;
    exc_accept = 1'b0;

    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (excepttype_i != 32'h0000_0000) begin
            flush      = 1'b1;
            new_pc     = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            pc_d       = new_pc;
            exc_accept = 1'b1;
            if (FLUSH_LEN > 1) begin
              state_d = ST_FLUSH_HOLD;
              hold_d  = HOLD_W'(FLUSH_LEN - 1);
            end
          end else if (stallreq_from_mem) begin
            stall = 6'b011111;
          end else if (stallreq_from_ex) begin
            stall = 6'b001111;
          end else if (stallreq_from_id || stallreq_from_if) begin
            stall = 6'b000111;
          end
        end
        ST_FLUSH_HOLD: begin
          flush  = 1'b1;
          new_pc = pc_q;
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q == HOLD_W'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Statistics and watchdog
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    exc_cnt_d   = exc_cnt_q;
    run_d       = '0;
    timeout_d   = timeout_q | (run_q == RUN_W'(STALL_TIMEOUT));

    if ((stall != 6'b000000) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (exc_accept && (exc_cnt_q != {CNT_W{1'b1}})) begin
      exc_cnt_d = exc_cnt_q + CNT_W'(1);
    end
    if ((stall != 6'b000000) && !flush) begin
      run_d = (run_q == RUN_W'(STALL_TIMEOUT)) ? run_q : run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      hold_q      <= '0;
      pc_q        <= 32'h0000_0000;
      stall_cnt_q <= '0;
      exc_cnt_q   <= '0;
      run_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      exc_cnt_q   <= exc_cnt_d;
      run_q       <= run_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cycles  = stall_cnt_q;
  assign exc_count     = exc_cnt_q;
  assign stall_timeout = timeout_q;

endmodule
